// File: rtl/coincidence_counter_if.sv
// Control, pulse and readout signals of the coincidence counter.
interface coincidence_counter_if #(
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned GATE_W = 32
);
   logic              start;
   logic [GATE_W-1:0] gate_len;
   logic              pulse_a;
   logic              pulse_b;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  cnt_a;
   logic [CNT_W-1:0]  cnt_b;
   logic [CNT_W-1:0]  cnt_ab;
   logic              overflow;

   // Counter side: consumes pulses/control, publishes results.
   modport master (
      input  start, gate_len, pulse_a, pulse_b, out_ready,
      output busy, out_valid, cnt_a, cnt_b, cnt_ab, overflow
   );

   // Host/readout side.
   modport slave (
      output start, gate_len, pulse_a, pulse_b, out_ready,
      input  busy, out_valid, cnt_a, cnt_b, cnt_ab, overflow
   );
endinterface

// File: rtl/coincidence_counter.sv
// Gated singles and A/B coincidence counter with valid/ready readout.
module coincidence_counter #(
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned GATE_W = 32,
   parameter int unsigned WIN    = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   coincidence_counter_if.master bus
);

   localparam int unsigned AGE_W = (WIN < 2) ? 1 : $clog2(WIN + 1);
   localparam logic [AGE_W-1:0] AGE_EXP = AGE_W'(WIN);
   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(WIN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [GATE_W-1:0] gate_q, gate_d;
   logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
   logic [CNT_W-1:0]  cnt_ab_q, cnt_ab_d;
   logic              ovf_q, ovf_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [AGE_W-1:0]  age_a_q, age_a_d;
   logic [AGE_W-1:0]  age_b_q, age_b_d;
   logic              pair;
   logic [CNT_W:0]    res_a, res_b, res_ab;

   // Saturating increment; MSB of the result flags a lost count.
   function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
      logic [CNT_W:0] r;
      if (!en) begin
         r = {1'b0, cnt};
      end else if (cnt == CNT_MAX) begin
         r = {1'b1, cnt};
      end else begin
         r = {1'b0, cnt + CNT_W'(1)};
      end
      return r;
   endfunction

   // Age of the last unpaired pulse: restart on a pulse, else count up to expiry.
   function automatic logic [AGE_W-1:0] age_next(input logic [AGE_W-1:0] age, input logic pulse);
      logic [AGE_W-1:0] r;
      if (pulse) begin
         r = '0;
      end else if (age >= AGE_EXP) begin
         r = AGE_EXP;
      end else begin
         r = age + AGE_W'(1);
      end
      return r;
   endfunction

   // Next-state: gate sequencing, singles, coincidence pairing and readout handshake.
   always_comb begin
      state_d  = state_q;
      gate_d   = gate_q;
      cnt_a_d  = cnt_a_q;
      cnt_b_d  = cnt_b_q;
      cnt_ab_d = cnt_ab_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      valid_d  = valid_q;
      age_a_d  = age_a_q;
      age_b_d  = age_b_q;
      pair     = 1'b0;
      res_a    = '0;
      res_b    = '0;
      res_ab   = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_COUNT;
               gate_d   = (bus.gate_len == '0) ? GATE_W'(1) : bus.gate_len;
               cnt_a_d  = '0;
               cnt_b_d  = '0;
               cnt_ab_d = '0;
               ovf_d    = 1'b0;
               age_a_d  = AGE_EXP;
               age_b_d  = AGE_EXP;
               busy_d   = 1'b1;
            end
         end

         S_COUNT: begin
            // Priority: same-cycle pair, then B closing an open A, then A closing an open B.
            if (bus.pulse_a && bus.pulse_b) begin
               pair = 1'b1;
            end else if (bus.pulse_b && (age_a_q < AGE_LIM)) begin
               pair = 1'b1;
            end else if (bus.pulse_a && (age_b_q < AGE_LIM)) begin
               pair = 1'b1;
            end

            if (pair) begin
               age_a_d = AGE_EXP;
               age_b_d = AGE_EXP;
            end else begin
               age_a_d = age_next(age_a_q, bus.pulse_a);
               age_b_d = age_next(age_b_q, bus.pulse_b);
            end

            res_a    = sat_inc(cnt_a_q, bus.pulse_a);
            res_b    = sat_inc(cnt_b_q, bus.pulse_b);
            res_ab   = sat_inc(cnt_ab_q, pair);
            cnt_a_d  = res_a[CNT_W-1:0];
            cnt_b_d  = res_b[CNT_W-1:0];
            cnt_ab_d = res_ab[CNT_W-1:0];
            ovf_d    = ovf_q | res_a[CNT_W] | res_b[CNT_W] | res_ab[CNT_W];

            if (gate_q == GATE_W'(1)) begin
               state_d = S_DONE;
               valid_d = 1'b1;
            end else begin
               gate_d = gate_q - GATE_W'(1);
            end
         end

         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         gate_q   <= '0;
         cnt_a_q  <= '0;
         cnt_b_q  <= '0;
         cnt_ab_q <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         age_a_q  <= AGE_EXP;
         age_b_q  <= AGE_EXP;
      end else begin
         state_q  <= state_d;
         gate_q   <= gate_d;
         cnt_a_q  <= cnt_a_d;
         cnt_b_q  <= cnt_b_d;
         cnt_ab_q <= cnt_ab_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         age_a_q  <= age_a_d;
         age_b_q  <= age_b_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.out_valid = valid_q;
   assign bus.cnt_a     = cnt_a_q;
   assign bus.cnt_b     = cnt_b_q;
   assign bus.cnt_ab    = cnt_ab_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_coincidence_counter.sv
// Directed bench: a 32-bit counter and a 4-bit counter see identical stimulus.
module tb_coincidence_counter;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   bit   pa [0:255];
   bit   pb [0:255];

   coincidence_counter_if #(.CNT_W(32), .GATE_W(32)) m_if ();
   coincidence_counter_if #(.CNT_W(4),  .GATE_W(32)) s_if ();

   assign s_if.start     = m_if.start;
   assign s_if.gate_len  = m_if.gate_len;
   assign s_if.pulse_a   = m_if.pulse_a;
   assign s_if.pulse_b   = m_if.pulse_b;
   assign s_if.out_ready = m_if.out_ready;

   coincidence_counter #(.CNT_W(32), .GATE_W(32), .WIN(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m_if.master)
   );

   coincidence_counter #(.CNT_W(4), .GATE_W(32), .WIN(4)) u_dut_small (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (s_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic clear_sched();
      for (int i = 0; i < 256; i++) begin
         pa[i] = 1'b0;
         pb[i] = 1'b0;
      end
   endtask

   // Cycle k=0 is the start cycle; vcyc is the first cycle with out_valid seen (-1 if none).
   task automatic run_gate(input int gl, input int ncyc, output int vcyc);
      vcyc = -1;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (vcyc < 0 && m_if.out_valid) vcyc = k;
         m_if.start    = (k == 0);
         m_if.gate_len = (k == 0) ? 32'(gl) : 32'd3;
         m_if.pulse_a  = pa[k];
         m_if.pulse_b  = pb[k];
      end
      @(negedge clk);
      if (vcyc < 0 && m_if.out_valid) vcyc = ncyc;
      m_if.start   = 1'b0;
      m_if.pulse_a = 1'b0;
      m_if.pulse_b = 1'b0;
   endtask

   // Leaves the bench at the negedge of the cycle after the handshake.
   task automatic do_handshake();
      @(negedge clk);
      m_if.out_ready = 1'b1;
      @(negedge clk);
      m_if.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (m_if.busy !== 1'b0 || m_if.out_valid !== 1'b0 || m_if.overflow !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got busy=%0b valid=%0b ovf=%0b expected 0 0 0",
                            m_if.busy, m_if.out_valid, m_if.overflow);
      end
      checks++; if (m_if.cnt_a !== 32'd0 || m_if.cnt_b !== 32'd0 || m_if.cnt_ab !== 32'd0) begin
         errors++; $display("FAIL reset_counts: got %0d %0d %0d expected 0 0 0",
                            m_if.cnt_a, m_if.cnt_b, m_if.cnt_ab);
      end
      rst_n = 1'b1;
      // Enter COUNT, count one A pulse, then reset mid-gate.
      @(negedge clk);
      m_if.start = 1'b1; m_if.gate_len = 32'd50;
      @(negedge clk);
      m_if.start = 1'b0; m_if.pulse_a = 1'b1;
      @(negedge clk);
      m_if.pulse_a = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (m_if.busy !== 1'b1 || m_if.cnt_a !== 32'd1) begin
         errors++; $display("FAIL midgate_pre: got busy=%0b cnt_a=%0d expected 1 1", m_if.busy, m_if.cnt_a);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (m_if.busy !== 1'b0 || m_if.out_valid !== 1'b0 || m_if.cnt_a !== 32'd0 ||
                    m_if.overflow !== 1'b0) begin
         errors++; $display("FAIL midgate_reset: got busy=%0b valid=%0b cnt_a=%0d ovf=%0b expected 0 0 0 0",
                            m_if.busy, m_if.out_valid, m_if.cnt_a, m_if.overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (m_if.busy !== 1'b0 || m_if.out_valid !== 1'b0) begin
         errors++; $display("FAIL midgate_idle: got busy=%0b valid=%0b expected 0 0", m_if.busy, m_if.out_valid);
      end
   endtask

   task automatic test_singles();
      int v;
      clear_sched();
      for (int i = 0; i < 7; i++) pa[2 + 12 * i] = 1'b1;
      for (int i = 0; i < 5; i++) pb[8 + 12 * i] = 1'b1;
      run_gate(100, 104, v);
      checks++; if (v !== 101) begin
         errors++; $display("FAIL singles_valid_cycle: got %0d expected 101", v);
      end
      checks++; if (m_if.cnt_a !== 32'd7) begin
         errors++; $display("FAIL singles_cnt_a: got %0d expected 7", m_if.cnt_a);
      end
      checks++; if (m_if.cnt_b !== 32'd5) begin
         errors++; $display("FAIL singles_cnt_b: got %0d expected 5", m_if.cnt_b);
      end
      checks++; if (m_if.cnt_ab !== 32'd0 || m_if.overflow !== 1'b0 || m_if.busy !== 1'b1) begin
         errors++; $display("FAIL singles_misc: got ab=%0d ovf=%0b busy=%0b expected 0 0 1",
                            m_if.cnt_ab, m_if.overflow, m_if.busy);
      end
      do_handshake();
      checks++; if (m_if.out_valid !== 1'b0 || m_if.busy !== 1'b0) begin
         errors++; $display("FAIL singles_handshake: got valid=%0b busy=%0b expected 0 0",
                            m_if.out_valid, m_if.busy);
      end
   endtask

   task automatic test_coincidence();
      int v;
      clear_sched();
      pa[10] = 1; pb[10] = 1;   // +0
      pa[20] = 1; pb[21] = 1;   // +1
      pa[30] = 1; pb[33] = 1;   // +3
      pa[40] = 1; pb[44] = 1;   // +4: outside window
      pa[60] = 1; pb[60] = 1;   // same cycle
      pb[70] = 1; pa[72] = 1;   // B first, +2
      pa[80] = 1; pb[81] = 1; pb[82] = 1;   // A pairs only once
      run_gate(100, 104, v);
      checks++; if (v !== 101) begin
         errors++; $display("FAIL coinc_valid_cycle: got %0d expected 101", v);
      end
      checks++; if (m_if.cnt_ab !== 32'd6) begin
         errors++; $display("FAIL coinc_cnt_ab: got %0d expected 6", m_if.cnt_ab);
      end
      checks++; if (m_if.cnt_a !== 32'd7 || m_if.cnt_b !== 32'd8) begin
         errors++; $display("FAIL coinc_singles: got a=%0d b=%0d expected 7 8", m_if.cnt_a, m_if.cnt_b);
      end
      do_handshake();
   endtask

   task automatic test_boundaries();
      int v;
      clear_sched();
      pa[0]  = 1;   // start cycle: ignored
      pb[1]  = 1;   // first counting cycle: counted, must not pair with pa[0]
      pa[20] = 1;   // last counting cycle: counted
      pb[21] = 1;   // first DONE cycle: ignored, must not pair
      run_gate(20, 24, v);
      checks++; if (v !== 21) begin
         errors++; $display("FAIL bound_valid_cycle: got %0d expected 21", v);
      end
      checks++; if (m_if.cnt_a !== 32'd1 || m_if.cnt_b !== 32'd1) begin
         errors++; $display("FAIL bound_singles: got a=%0d b=%0d expected 1 1", m_if.cnt_a, m_if.cnt_b);
      end
      checks++; if (m_if.cnt_ab !== 32'd0) begin
         errors++; $display("FAIL bound_cnt_ab: got %0d expected 0", m_if.cnt_ab);
      end
      do_handshake();
   endtask

   task automatic test_zero_gate_hold();
      int v;
      int bad;
      clear_sched();
      pa[1] = 1;
      pa[2] = 1;
      run_gate(0, 4, v);
      checks++; if (v !== 2) begin
         errors++; $display("FAIL zero_valid_cycle: got %0d expected 2", v);
      end
      checks++; if (m_if.cnt_a !== 32'd1) begin
         errors++; $display("FAIL zero_cnt_a: got %0d expected 1", m_if.cnt_a);
      end
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (m_if.out_valid !== 1'b1 || m_if.busy !== 1'b1 || m_if.cnt_a !== 32'd1 ||
             m_if.cnt_b !== 32'd0 || m_if.cnt_ab !== 32'd0 || m_if.overflow !== 1'b0) bad++;
         m_if.start    = k[0];
         m_if.gate_len = 32'(k + 7);
         m_if.pulse_a  = k[1];
         m_if.pulse_b  = k[2];
      end
      checks++; if (bad !== 0) begin
         errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
      end
      m_if.pulse_a = 1'b0; m_if.pulse_b = 1'b0;
      @(negedge clk);
      m_if.out_ready = 1'b1; m_if.start = 1'b1; m_if.gate_len = 32'd10;
      @(negedge clk);
      m_if.out_ready = 1'b0; m_if.start = 1'b0;
      checks++; if (m_if.out_valid !== 1'b0 || m_if.busy !== 1'b0) begin
         errors++; $display("FAIL hold_release: got valid=%0b busy=%0b expected 0 0", m_if.out_valid, m_if.busy);
      end
      @(negedge clk);
      checks++; if (m_if.busy !== 1'b0) begin
         errors++; $display("FAIL hold_start_ignored: got busy=%0b expected 0", m_if.busy);
      end
   endtask

   task automatic test_saturation();
      int v;
      clear_sched();
      for (int i = 1; i <= 20; i++) pa[i] = 1'b1;
      run_gate(30, 34, v);
      checks++; if (v !== 31) begin
         errors++; $display("FAIL sat_valid_cycle: got %0d expected 31", v);
      end
      checks++; if (s_if.cnt_a !== 4'd15 || s_if.overflow !== 1'b1) begin
         errors++; $display("FAIL sat_small: got cnt_a=%0d ovf=%0b expected 15 1", s_if.cnt_a, s_if.overflow);
      end
      checks++; if (m_if.cnt_a !== 32'd20 || m_if.overflow !== 1'b0) begin
         errors++; $display("FAIL sat_wide: got cnt_a=%0d ovf=%0b expected 20 0", m_if.cnt_a, m_if.overflow);
      end
      do_handshake();
      checks++; if (s_if.overflow !== 1'b1) begin
         errors++; $display("FAIL sat_sticky_idle: got ovf=%0b expected 1", s_if.overflow);
      end
      clear_sched();
      run_gate(5, 8, v);
      checks++; if (v !== 6) begin
         errors++; $display("FAIL sat_next_valid_cycle: got %0d expected 6", v);
      end
      checks++; if (s_if.overflow !== 1'b0 || s_if.cnt_a !== 4'd0) begin
         errors++; $display("FAIL sat_cleared: got ovf=%0b cnt_a=%0d expected 0 0", s_if.overflow, s_if.cnt_a);
      end
      do_handshake();
   endtask

   initial begin
      rst_n          = 1'b1;
      m_if.start     = 1'b0;
      m_if.gate_len  = 32'd0;
      m_if.pulse_a   = 1'b0;
      m_if.pulse_b   = 1'b0;
      m_if.out_ready = 1'b0;
      test_reset();
      test_singles();
      test_coincidence();
      test_boundaries();
      test_zero_gate_hold();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
